// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Time-shares one external combinational ALU between two requesters.
//   Round-robin grant in IDLE, one registered operand stage (EXEC) and one
//   registered result stage (RESP) held until the owning requester accepts.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no operation in flight; grant arbitration open
//   EXEC  | operand register drives the ALU; result captured at cycle end
//   RESP  | result held, rsp_valid[owner] high until rsp_ready[owner]
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready [1:0]     request handshake, bit i = requester i
//   req0_a/b/sel, req1_a/b/sel    requester operands and opcode
//   rsp_valid/rsp_ready [1:0]     response handshake, bit i = requester i
//   rsp_out, rsp_cf/of/zf         registered result and flags (shared)
//   alu_a/b/sel                   drive to the external ALU
//   alu_out, alu_cf/of/zf         result from the external ALU
//   busy                          state is not IDLE
//   op_count                      completed response handshakes (wraps)
module alu_share_arb #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_sel,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_sel,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_out,
   output logic             rsp_cf,
   output logic             rsp_of,
   output logic             rsp_zf,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_cf,
   input  logic             alu_of,
   input  logic             alu_zf,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state;
   logic             last_grant;
   logic             owner;
   logic             grant;
   logic             accept;
   logic             done;
   logic             arith_op;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [2:0]       op_sel;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant = 1'b0;
      case (req_valid)
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

   assign accept    = (state == IDLE) && req_valid[grant];
   assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign done      = (state == RESP) && rsp_ready[owner];
   assign busy      = (state != IDLE);

   assign alu_a   = op_a;
   assign alu_b   = op_b;
   assign alu_sel = op_sel;

   // Only ADD (000) and SUB (001) produce meaningful carry/overflow; other
   // opcodes leave stale flags on the ALU outputs, so they are masked.
   assign arith_op = (op_sel[2:1] == 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         op_sel     <= '0;
         rsp_out    <= '0;
         rsp_cf     <= 1'b0;
         rsp_of     <= 1'b0;
         rsp_zf     <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_a   <= grant ? req1_a   : req0_a;
                  op_b   <= grant ? req1_b   : req0_b;
                  op_sel <= grant ? req1_sel : req0_sel;
                  owner  <= grant;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_out <= alu_out;
               rsp_zf  <= alu_zf;
               rsp_cf  <= arith_op & alu_cf;
               rsp_of  <= arith_op & alu_of;
               state   <= RESP;
            end
            RESP: begin
               if (done) begin
                  last_grant <= owner;
                  op_count   <= op_count + CNT_W'(1);
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
